bus_uart: RTL

BUS_UART -- requirements
Module: bus_uart

---
 rtl/bus_uart.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX shifter, synchronized RX sampler, small RX FIFO,
// DATA/STATUS registers with registered read data and sticky error flags.
module bus_uart #(
    parameter int DIVISOR    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       ra,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    output logic [7:0] rdata,
    input  logic       ftdi_rx,
    output logic       ftdi_tx
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_END  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_END = 16'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    logic       wr_data, rd_any;
    assign wr_data = cs & we & ~ra;
    assign rd_any  = cs & re;

    // TX
    state_e      tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
            case (tx_state_q)
                ST_IDLE: if (wr_data) begin
                    tx_sh_q    <= wdata;
                    tx_q       <= 1'b0;
                    tx_cnt_q   <= '0;
                    tx_state_q <= ST_START;
                end
                ST_START: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q   <= '0;
                    tx_bit_q   <= '0;
                    tx_q       <= tx_sh_q[0];
                    tx_state_q <= ST_DATA;
                end
                ST_DATA: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_q       <= 1'b1;
                        tx_state_q <= ST_STOP;
                    end else begin
                        tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                        tx_q    <= tx_sh_q[1];
                    end
                end
                ST_STOP: if (tx_cnt_q == BIT_END) tx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign ftdi_tx = tx_q;

    // RX: sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detect
    logic [2:0]  sync_q;
    logic        rx_s, rx_fall;
    state_e      rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_wait_q, push_q, ferr_q;

    assign rx_s    = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 3'b111;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_wait_q  <= 1'b0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], ftdi_rx};
            rx_cnt_q <= rx_cnt_q + 16'd1;
            push_q   <= 1'b0;
            ferr_q   <= 1'b0;
            case (rx_state_q)
                ST_IDLE: if (rx_fall) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= ST_START;
                end
                ST_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_wait_q  <= 1'b0;
                        rx_state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rx_wait_q) begin
                        if (rx_s) rx_state_q <= ST_IDLE;
                    end else if (rx_cnt_q == BIT_END) begin
                        if (rx_s) begin
                            push_q     <= 1'b1;
                            rx_state_q <= ST_IDLE;
                        end else begin
                            ferr_q    <= 1'b1;
                            rx_wait_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // FIFO, flags and read mux
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [7:0]    rdata_q, rdata_d, status;
    logic          pop, full, push_ok, clr;

    always_comb begin
        full        = (count_q == CNT_FULL);
        pop         = rd_any & ~ra & (count_q != '0);
        push_ok     = push_q & (~full | pop);
        clr         = rd_any & ra;
        status      = {3'b000, frame_err_q, overrun_q, full, count_q != '0, tx_state_q != ST_IDLE};
        wptr_d      = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d      = pop ? rptr_q + AW'(1) : rptr_q;
        count_d     = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (pop && !push_ok) count_d = count_q - CW'(1);
        // a same-cycle flag event outranks the clear-on-read
        overrun_d   = (overrun_q & ~clr) | (push_q & full & ~pop);
        frame_err_d = (frame_err_q & ~clr) | ferr_q;
        rdata_d     = rdata_q;
        if (rd_any) rdata_d = ra ? status : ((count_q != '0) ? mem_q[rptr_q] : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= rx_sh_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule
